// File: rtl/hg_turn_seq_pkg.sv
// Shared types and constants for the hourglass turn sequencer.
// Turn-bit positions index the 2-bit schedule entries.
package hg_turn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TURN_SMALL = 0;
    localparam int TURN_LARGE = 1;

    localparam int SMALL = 4;
    localparam int LARGE = 7;

endpackage

// File: rtl/hg_sched_mem.sv
// Schedule register file: DEPTH x 2 bits, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module hg_sched_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [1:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [1:0]    o_rdata
);

    logic [1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hg_turn_seq.sv
// Plays a programmed schedule of hourglass turn commands until the downstream
// model reports done, failure, or the schedule runs out.
module hg_turn_seq
    import hg_turn_seq_pkg::*;
#(
    parameter int MSB   = 7,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [1:0]                 prog_data,
    input  logic [$clog2(DEPTH):0]     prog_len,
    input  logic                       start,
    input  logic [MSB:0]               target,
    input  logic                       hg_done,
    input  logic                       hg_failed,
    output logic                       busy,
    output logic [MSB:0]               startTime,
    output logic                       turnSmall,
    output logic                       turnLarge,
    output logic                       result_valid,
    output logic                       result_ok,
    output logic [$clog2(DEPTH):0]     result_steps
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

    state_t          r_state;
    logic [MSB:0]    r_start_time;
    logic [AW-1:0]   r_step;
    logic [LW-1:0]   r_len;
    logic            r_ok;
    logic [LW-1:0]   r_steps;
    logic            r_valid;

    logic [1:0]      w_entry;
    logic            w_len_ok;
    logic            w_last;
    logic            w_idle;

    assign w_idle   = (r_state == IDLE);
    assign w_len_ok = (prog_len != '0) && (prog_len <= LEN_MAX);
    // step stays below len, so the last entry is reached before step could wrap
    assign w_last   = ({1'b0, r_step} == (r_len - 1'b1));

    hg_sched_mem #(.DEPTH(DEPTH)) u_sched (
        .clock   (clock),
        .i_we    (prog_we && w_idle),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_step),
        .o_rdata (w_entry)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_start_time <= '0;
            r_step       <= '0;
            r_len        <= '0;
            r_ok         <= 1'b0;
            r_steps      <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && w_len_ok) begin
                        r_start_time <= target;
                        r_len        <= prog_len;
                        r_step       <= '0;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    // hg_done outranks hg_failed, which outranks exhaustion
                    if (hg_done || hg_failed || w_last) begin
                        r_ok    <= hg_done;
                        r_steps <= {1'b0, r_step} + 1'b1;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_step  <= r_step + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = !w_idle;
    assign startTime    = r_start_time;
    assign turnSmall    = (r_state == RUN) && w_entry[TURN_SMALL];
    assign turnLarge    = (r_state == RUN) && w_entry[TURN_LARGE];
    assign result_valid = r_valid;
    assign result_ok    = r_ok;
    assign result_steps = r_steps;

endmodule

// File: tb/tb_hg_turn_seq.sv
// Scoreboard bench for hg_turn_seq: the driver pushes expected turns/results
// computed from a run-level model; a negedge monitor pops and compares.
module tb_hg_turn_seq;

    localparam int MSB   = 7;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [1:0]    prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic [MSB:0]  target = '0;
    logic          hg_done = 1'b0;
    logic          hg_failed = 1'b0;
    logic          busy;
    logic [MSB:0]  startTime;
    logic          turnSmall;
    logic          turnLarge;
    logic          result_valid;
    logic          result_ok;
    logic [AW:0]   result_steps;

    hg_turn_seq #(.MSB(MSB), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_len     (prog_len),
        .start        (start),
        .target       (target),
        .hg_done      (hg_done),
        .hg_failed    (hg_failed),
        .busy         (busy),
        .startTime    (startTime),
        .turnSmall    (turnSmall),
        .turnLarge    (turnLarge),
        .result_valid (result_valid),
        .result_ok    (result_ok),
        .result_steps (result_steps)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ok;
        int steps;
        int st;
    } res_t;

    int         chk = 0;
    int         err = 0;
    logic [1:0] sched_m [DEPTH];
    res_t       rq[$];
    int         tq[$];

    task automatic check(input string name, input int act, input int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every RUN cycle must match the next expected turn; every
    // result strobe must match the next expected result.
    always @(negedge clock) begin
        res_t r;
        if (resetn) begin
            if (result_valid) begin
                if (rq.size() == 0) begin
                    chk++; err++;
                    $display("FAIL unexpected_result_valid at %0t", $time);
                end else begin
                    r = rq.pop_front();
                    check("result_ok", int'(result_ok), r.ok);
                    check("result_steps", int'(result_steps), r.steps);
                    check("startTime", int'(startTime), r.st);
                    check("turns_in_done", int'({turnLarge, turnSmall}), 0);
                end
            end else if (busy) begin
                if (tq.size() == 0) begin
                    chk++; err++;
                    $display("FAIL unexpected_run_cycle at %0t", $time);
                end else begin
                    check("turn", int'({turnLarge, turnSmall}), tq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int a, input logic [1:0] d);
        prog_we   = 1'b1;
        prog_addr = a[AW-1:0];
        prog_data = d;
        tick();
        prog_we   = 1'b0;
        sched_m[a] = d;
    endtask

    // dc/fc: 1-based RUN cycle in which hg_done/hg_failed is raised (0 = never)
    task automatic run(input int len, input int tgt, input int dc, input int fc, input bit noise);
        int   c;
        int   ok;
        int   i;
        res_t r;
        c = len;
        if (fc != 0 && fc < c) c = fc;
        if (dc != 0 && dc <= c) c = dc;
        ok = (dc != 0 && dc == c) ? 1 : 0;
        for (int k = 0; k < c; k++) tq.push_back(int'(sched_m[k]));
        r.ok = ok; r.steps = c; r.st = tgt;
        rq.push_back(r);
        start    = 1'b1;
        prog_len = len[AW:0];
        target   = tgt[MSB:0];
        tick();
        start = 1'b0;
        i = 1;
        forever begin
            hg_done   = (i == dc);
            hg_failed = (i == fc);
            if (noise) begin
                prog_we   = 1'b1;
                prog_addr = AW'($urandom);
                prog_data = 2'($urandom);
                start     = 1'b1;
                prog_len  = 5'd2;
                target    = 8'hEE;
            end
            tick();
            if (result_valid) break;
            i++;
            if (i > DEPTH + 4) begin
                chk++; err++;
                $display("FAIL run_timeout len %0d", len);
                break;
            end
        end
        hg_done = 1'b0; hg_failed = 1'b0; prog_we = 1'b0; start = 1'b0;
        tick();
        check("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        resetn = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_turns", int'({turnLarge, turnSmall}), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_ok", int'(result_ok), 0);
        check("rst_steps", int'(result_steps), 0);
        check("rst_startTime", int'(startTime), 0);
        resetn = 1'b1;
        tick();

        wr(0, 2'b01); wr(1, 2'b10); wr(2, 2'b11);
        run(3, 4, 2, 0, 1'b0);
        run(3, 5, 0, 1, 1'b0);
        run(3, 9, 0, 0, 1'b0);

        // Illegal lengths are ignored
        start = 1'b1; prog_len = 5'd0; target = 8'd77;
        tick();
        check("len0_busy", int'(busy), 0);
        prog_len = 5'd17;
        tick();
        start = 1'b0;
        repeat (3) begin
            check("badlen_busy", int'(busy), 0);
            tick();
        end
        check("badlen_startTime", int'(startTime), 9);

        // Writes and starts during RUN must not disturb the schedule
        run(3, 6, 0, 0, 1'b1);
        run(3, 7, 0, 0, 1'b0);

        run(3, 8, 2, 2, 1'b0);
        run(3, 10, 1, 1, 1'b0);

        for (int a = 0; a < DEPTH; a++) wr(a, 2'($urandom));

        // Abort mid-run with reset: only three turns observed, no result
        for (int k = 0; k < 3; k++) tq.push_back(int'(sched_m[k]));
        start = 1'b1; prog_len = 5'd8; target = 8'd33;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        resetn = 1'b0;
        tick();
        check("abort_busy", int'(busy), 0);
        check("abort_turns", int'({turnLarge, turnSmall}), 0);
        check("abort_valid", int'(result_valid), 0);
        check("abort_startTime", int'(startTime), 0);
        resetn = 1'b1;
        tick();
        tick();
        check("abort_idle", int'(busy), 0);

        run(16, 100, 0, 0, 1'b0);
        run(16, 50, 16, 0, 1'b0);
        run(16, 51, 0, 16, 1'b0);

        repeat (25) begin
            int len;
            wr(int'($urandom_range(0, DEPTH - 1)), 2'($urandom));
            len = int'($urandom_range(1, DEPTH));
            run(len, int'($urandom_range(0, 255)), int'($urandom_range(0, 18)),
                int'($urandom_range(0, 18)), 1'($urandom));
        end

        tick(); tick();
        check("queues_drained", rq.size() + tq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
